// File: rtl/ffmode_chain_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ffmode_pkg
//  Description : Shared constants and helpers for the ffmode chain bank.
//                EDGE_POS / EDGE_NEG encode the active clock edge of a
//                channel; mask_bit() extracts one channel's mode bit from a
//                per-channel mask; cnt_width() sizes the load counter.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package ffmode_pkg;

   localparam bit EDGE_POS = 1'b0;
   localparam bit EDGE_NEG = 1'b1;

   // Bit idx of a per-channel mode mask.
   function automatic bit mask_bit(input logic [31:0] mask, input int idx);
      return |(mask & (32'd1 << idx));
   endfunction

   // Counter must be able to hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ffmode_chain_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : ffmode_chain_bank_if
//  Description : Data/control bundle of the ffmode chain bank.
//  Signals     : cen    [CHANNELS]        per-channel clock enable
//                srst                     shared synchronous set/reset
//                din    [CHANNELS*WIDTH]  channel c at din[c*WIDTH +: WIDTH]
//                dout   [CHANNELS*WIDTH]  last stage of each chain
//                primed [CHANNELS]        chain fully loaded since reset
//  Modports    : master (stimulus side), slave (bank side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ffmode_chain_bank_if #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 2
);
   logic [CHANNELS-1:0]       cen;
   logic                      srst;
   logic [CHANNELS*WIDTH-1:0] din;
   logic [CHANNELS*WIDTH-1:0] dout;
   logic [CHANNELS-1:0]       primed;

   modport master (
      output cen, srst, din,
      input  dout, primed
   );

   modport slave (
      input  cen, srst, din,
      output dout, primed
   );
endinterface
`default_nettype wire

// File: rtl/ffmode_chain_bank_chan.sv
`default_nettype none
// ============================================================================
//  Module      : ffmode_chain_chan
//  Description : One DEPTH-stage, WIDTH-bit register chain with selectable
//                clock edge, optional clock enable, optional enable-gated
//                synchronous set/reset and async reset value, plus a
//                saturating load counter driving 'primed'.
//  Ports       : clk, rst (async, active-high), cen, srst, din[WIDTH],
//                dout[WIDTH] (last stage), primed
//  Revision    : 1.0 - initial release
// ============================================================================
module ffmode_chain_chan
   import ffmode_pkg::*;
#(
   parameter int WIDTH    = 2,
   parameter int DEPTH    = 2,
   parameter bit NEG      = EDGE_POS,
   parameter bit USE_CE   = 1'b1,
   parameter bit USE_SRST = 1'b1,
   parameter bit SRST_VAL = 1'b0,
   parameter bit ARST_VAL = 1'b0
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             cen,
   input  wire logic             srst,
   input  wire logic [WIDTH-1:0] din,
   output logic      [WIDTH-1:0] dout,
   output logic                  primed
);

   localparam int                           CW        = cnt_width(DEPTH);
   localparam logic [CW-1:0]                CNT_MAX   = CW'(DEPTH);
   localparam logic [DEPTH-1:0][WIDTH-1:0]  ARST_FILL = {(DEPTH*WIDTH){ARST_VAL}};
   localparam logic [DEPTH-1:0][WIDTH-1:0]  SRST_FILL = {(DEPTH*WIDTH){SRST_VAL}};

   logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic                        primed_q, primed_d;
   logic                        en_w;
   logic                        sr_w;

   // Inputs are always read so that disabled features simply mask them.
   assign en_w = cen | ~USE_CE;
   assign sr_w = srst & USE_SRST;

   // Sync reset only acts on enabled edges (SB_DFFESR/SB_DFFESS behaviour).
   always_comb begin
      stage_d  = stage_q;
      cnt_d    = cnt_q;
      primed_d = primed_q;
      if (en_w) begin
         if (sr_w) begin
            stage_d  = SRST_FILL;
            cnt_d    = '0;
            primed_d = 1'b0;
         end else begin
            stage_d[0] = din;
            for (int k = 1; k < DEPTH; k++) begin
               stage_d[k] = stage_q[k-1];
            end
            // Saturate rather than wrap so primed stays high.
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
            primed_d = (cnt_d == CNT_MAX);
         end
      end
   end

   if (NEG == EDGE_NEG) begin : g_neg
      always_ff @(negedge clk or posedge rst) begin
         if (rst) begin
            stage_q  <= ARST_FILL;
            cnt_q    <= '0;
            primed_q <= 1'b0;
         end else begin
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
         end
      end
   end else begin : g_pos
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            stage_q  <= ARST_FILL;
            cnt_q    <= '0;
            primed_q <= 1'b0;
         end else begin
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
         end
      end
   end

   assign dout   = stage_q[DEPTH-1];
   assign primed = primed_q;

endmodule
`default_nettype wire

// File: rtl/ffmode_chain_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ffmode_chain_bank
//  Description : Bank of CHANNELS independent register chains, each with its
//                own clock edge, clock-enable use, sync set/reset and async
//                reset value chosen by per-channel mode masks.
//  Ports       : clk, rst (async, active-high),
//                bus (slave): cen, srst, din, dout, primed
//  Revision    : 1.0 - initial release
// ============================================================================
module ffmode_chain_bank
   import ffmode_pkg::*;
#(
   parameter int                  CHANNELS      = 4,
   parameter int                  WIDTH         = 2,
   parameter int                  DEPTH         = 2,
   parameter logic [CHANNELS-1:0] NEG_MASK      = '0,
   parameter logic [CHANNELS-1:0] CE_MASK       = '1,
   parameter logic [CHANNELS-1:0] SRST_MASK     = '1,
   parameter logic [CHANNELS-1:0] SRST_VAL_MASK = '0,
   parameter logic [CHANNELS-1:0] ARST_VAL_MASK = '0
) (
   input wire logic           clk,
   input wire logic           rst,
   ffmode_chain_bank_if.slave bus
);

   logic [CHANNELS*WIDTH-1:0] dout_w;
   logic [CHANNELS-1:0]       primed_w;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      ffmode_chain_chan #(
         .WIDTH    (WIDTH),
         .DEPTH    (DEPTH),
         .NEG      (mask_bit(32'(NEG_MASK), c) ? EDGE_NEG : EDGE_POS),
         .USE_CE   (mask_bit(32'(CE_MASK), c)),
         .USE_SRST (mask_bit(32'(SRST_MASK), c)),
         .SRST_VAL (mask_bit(32'(SRST_VAL_MASK), c)),
         .ARST_VAL (mask_bit(32'(ARST_VAL_MASK), c))
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .cen    (bus.cen[c]),
         .srst   (bus.srst),
         .din    (bus.din[c*WIDTH +: WIDTH]),
         .dout   (dout_w[c*WIDTH +: WIDTH]),
         .primed (primed_w[c])
      );
   end

   assign bus.dout   = dout_w;
   assign bus.primed = primed_w;

endmodule
`default_nettype wire

// File: tb/tb_ffmode_chain_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ffmode_chain_bank
//  Description : Self-checking bench for ffmode_chain_bank. Four bank
//                configurations run side by side on a shared clk/rst with
//                independent random cen/srst/din. A reference model (load
//                history + fill value per channel) pushes expected outputs
//                into a scoreboard; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ffmode_chain_bank;

   // Configuration A: all posedge, all CE, srst values 0010, arst 0101.
   localparam logic [3:0] A_NEG = 4'b0000, A_CE = 4'b1111, A_SR = 4'b1111,
                          A_SRV = 4'b0010, A_ARV = 4'b0101;
   // Configuration B: channel 3 on negedge, channel 0 ignores cen.
   localparam logic [3:0] B_NEG = 4'b1000, B_CE = 4'b1110, B_SR = 4'b1111,
                          B_SRV = 4'b1001, B_ARV = 4'b0011;
   // Configuration C: DEPTH=3, mixed edges, channel 2 ignores srst.
   localparam logic [3:0] C_NEG = 4'b0101, C_CE = 4'b1011, C_SR = 4'b1011,
                          C_SRV = 4'b0110, C_ARV = 4'b1100;
   // Configuration D: CHANNELS=1, WIDTH=1, DEPTH=1.

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ffmode_chain_bank_if #(.CHANNELS(4), .WIDTH(2)) bus_a ();
   ffmode_chain_bank_if #(.CHANNELS(4), .WIDTH(2)) bus_b ();
   ffmode_chain_bank_if #(.CHANNELS(4), .WIDTH(2)) bus_c ();
   ffmode_chain_bank_if #(.CHANNELS(1), .WIDTH(1)) bus_d ();

   ffmode_chain_bank #(.CHANNELS(4), .WIDTH(2), .DEPTH(2),
      .NEG_MASK(A_NEG), .CE_MASK(A_CE), .SRST_MASK(A_SR),
      .SRST_VAL_MASK(A_SRV), .ARST_VAL_MASK(A_ARV))
      u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));

   ffmode_chain_bank #(.CHANNELS(4), .WIDTH(2), .DEPTH(2),
      .NEG_MASK(B_NEG), .CE_MASK(B_CE), .SRST_MASK(B_SR),
      .SRST_VAL_MASK(B_SRV), .ARST_VAL_MASK(B_ARV))
      u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   ffmode_chain_bank #(.CHANNELS(4), .WIDTH(2), .DEPTH(3),
      .NEG_MASK(C_NEG), .CE_MASK(C_CE), .SRST_MASK(C_SR),
      .SRST_VAL_MASK(C_SRV), .ARST_VAL_MASK(C_ARV))
      u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));

   ffmode_chain_bank #(.CHANNELS(1), .WIDTH(1), .DEPTH(1),
      .NEG_MASK(1'b0), .CE_MASK(1'b1), .SRST_MASK(1'b1),
      .SRST_VAL_MASK(1'b1), .ARST_VAL_MASK(1'b0))
      u_dut_d (.clk(clk), .rst(rst), .bus(bus_d));

   // Model configuration tables (index = configuration A..D).
   int         n_ch  [4];
   int         n_w   [4];
   int         n_dep [4];
   logic [3:0] neg_m [4];
   logic [3:0] ce_m  [4];
   logic [3:0] sr_m  [4];
   logic [3:0] srv_m [4];
   logic [3:0] arv_m [4];

   // Stimulus values.
   logic [3:0] cen_v  [4];
   logic       srst_v [4];
   logic [7:0] din_v  [4];

   // Model state: loads since last reset, fill value after last reset,
   // and the history of loaded values.
   int         loads [4][4];
   logic [1:0] fill  [4][4];
   logic [1:0] hist  [4][4][64];

   // Observed outputs gathered into uniform arrays.
   logic [7:0] dout_m   [4];
   logic [3:0] primed_m [4];
   always_comb begin
      dout_m[0]   = bus_a.dout;
      dout_m[1]   = bus_b.dout;
      dout_m[2]   = bus_c.dout;
      dout_m[3]   = {7'b0, bus_d.dout};
      primed_m[0] = bus_a.primed;
      primed_m[1] = bus_b.primed;
      primed_m[2] = bus_c.primed;
      primed_m[3] = {3'b0, bus_d.primed};
   end

   typedef struct {
      int         d;
      logic [7:0] dout;
      logic [3:0] primed;
   } exp_t;

   exp_t sb[$];
   event sample_ev;
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [1:0] rep(input logic b, input int w);
      if (!b) return 2'b00;
      return (w == 2) ? 2'b11 : 2'b01;
   endfunction

   task automatic apply_inputs();
      bus_a.cen  = cen_v[0];  bus_a.srst = srst_v[0]; bus_a.din = din_v[0];
      bus_b.cen  = cen_v[1];  bus_b.srst = srst_v[1]; bus_b.din = din_v[1];
      bus_c.cen  = cen_v[2];  bus_c.srst = srst_v[2]; bus_c.din = din_v[2];
      bus_d.cen  = cen_v[3][0:0];
      bus_d.srst = srst_v[3];
      bus_d.din  = din_v[3][0:0];
   endtask

   // 0: fixed A5, full enable; 2: random din, full enable;
   // 3: srst with cen=0011; 4: cen all low; 1: fully random.
   task automatic gen_inputs(input int mode);
      for (int d = 0; d < 4; d++) begin
         case (mode)
            0: begin cen_v[d] = 4'hF; srst_v[d] = 1'b0; din_v[d] = 8'hA5; end
            2: begin cen_v[d] = 4'hF; srst_v[d] = 1'b0; din_v[d] = 8'($urandom); end
            3: begin cen_v[d] = 4'b0011; srst_v[d] = 1'b1; din_v[d] = 8'($urandom); end
            4: begin cen_v[d] = 4'h0; srst_v[d] = 1'b0; din_v[d] = 8'($urandom); end
            default: begin
               cen_v[d]  = 4'($urandom | $urandom);
               srst_v[d] = ($urandom_range(0, 7) == 0);
               din_v[d]  = 8'($urandom);
            end
         endcase
      end
      apply_inputs();
   endtask

   task automatic model_reset();
      for (int d = 0; d < 4; d++)
         for (int c = 0; c < n_ch[d]; c++) begin
            loads[d][c] = 0;
            fill[d][c]  = rep(arv_m[d][c], n_w[d]);
         end
   endtask

   task automatic model_edge(input logic is_neg);
      logic [7:0] t;
      logic [1:0] v;
      for (int d = 0; d < 4; d++)
         for (int c = 0; c < n_ch[d]; c++) begin
            if (neg_m[d][c] != is_neg) continue;
            if (ce_m[d][c] && !cen_v[d][c]) continue;
            if (sr_m[d][c] && srst_v[d]) begin
               fill[d][c]  = rep(srv_m[d][c], n_w[d]);
               loads[d][c] = 0;
            end else begin
               t = din_v[d] >> (c * n_w[d]);
               v = (n_w[d] == 2) ? t[1:0] : {1'b0, t[0]};
               hist[d][c][loads[d][c] % 64] = v;
               loads[d][c]++;
            end
         end
   endtask

   // The last stage shows the value loaded DEPTH loads ago, or the fill
   // value if fewer than DEPTH loads happened since the last reset.
   task automatic push_expected();
      exp_t       e;
      logic [1:0] v;
      for (int d = 0; d < 4; d++) begin
         e.d = d; e.dout = '0; e.primed = '0;
         for (int c = 0; c < n_ch[d]; c++) begin
            if (loads[d][c] >= n_dep[d]) begin
               v = hist[d][c][(loads[d][c] - n_dep[d]) % 64];
               e.primed[c] = 1'b1;
            end else begin
               v = fill[d][c];
            end
            e.dout = e.dout | (8'(v) << (c * n_w[d]));
         end
         sb.push_back(e);
      end
      ->sample_ev;
   endtask

   function automatic int mode_for(input int j);
      if (j <= 6)  return 0;
      if (j <= 8)  return 3;
      if (j <= 30) return 2;
      if (j <= 36) return 4;
      return 1;
   endfunction

   function automatic bit rst_at(input int i);
      return (i == 30) || (i == 140) || (i == 275) ||
             (i > 40 && $urandom_range(0, 59) == 0);
   endfunction

   task automatic half_step(input int i);
      @(clk);
      model_edge(clk == 1'b0);
      #1 push_expected();
      #1 gen_inputs(mode_for(i + 1));
      if (rst_at(i)) begin
         rst = 1'b1;
         model_reset();
         #1 push_expected();
         #1 rst = 1'b0;
      end
   endtask

   // Monitor: pops one expectation per configuration at each sample point.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         for (int k = 0; k < 4; k++) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL scoreboard_empty @%0t: got 0 entries, expected >0", $time);
            end else begin
               e = sb.pop_front();
               n_tests++;
               if (dout_m[e.d] !== e.dout) begin
                  n_fail++;
                  $display("FAIL dout cfg%0d @%0t: got %h, expected %h",
                           e.d, $time, dout_m[e.d], e.dout);
               end
               n_tests++;
               if (primed_m[e.d] !== e.primed) begin
                  n_fail++;
                  $display("FAIL primed cfg%0d @%0t: got %b, expected %b",
                           e.d, $time, primed_m[e.d], e.primed);
               end
            end
         end
      end
   end

   initial begin
      n_ch  = '{4, 4, 4, 1};
      n_w   = '{2, 2, 2, 1};
      n_dep = '{2, 2, 3, 1};
      neg_m = '{A_NEG, B_NEG, C_NEG, 4'b0000};
      ce_m  = '{A_CE,  B_CE,  C_CE,  4'b0001};
      sr_m  = '{A_SR,  B_SR,  C_SR,  4'b0001};
      srv_m = '{A_SRV, B_SRV, C_SRV, 4'b0001};
      arv_m = '{A_ARV, B_ARV, C_ARV, 4'b0000};

      gen_inputs(0);
      #1 rst = 1'b1;
      model_reset();
      #2 push_expected();
      #1 rst = 1'b0;

      for (int i = 0; i < 400; i++) begin
         half_step(i);
      end

      #2;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ffmode_chain_bank.md
Name: ffmode_chain_bank

Overview:
- Parametrised bank of independent register chains, used as a packer stress/regression block for the iCE40 DFF variants: SB_DFF{N}{E}{S|R}{SS|SR}.
- Each channel is a DEPTH-stage shift chain of WIDTH bits.
- Per-channel mode masks select the clock edge, clock-enable use, synchronous set/reset, and asynchronous set/reset value.
- Each channel also reports when its chain has been fully primed since its last reset.

Parameters:
- CHANNELS, 4, number of independent chains.
- WIDTH, 2, data bits per channel.
- DEPTH, 2, stages per chain (>=1).
- NEG_MASK, 4'b0000, bit c=1: channel c clocks on negedge clk.
- CE_MASK, 4'b1111, bit c=1: channel c honours cen[c]; 0: always enabled.
- SRST_MASK, 4'b1111, bit c=1: channel c honours srst.
- SRST_VAL_MASK, 4'b0000, bit c: value (replicated over WIDTH) loaded on sync reset.
- ARST_VAL_MASK, 4'b0000, bit c: value (replicated over WIDTH) forced by rst; also the power-up init value.

Ports:
- clk  input  1  clock; edge per channel selected by NEG_MASK.
- rst  input  1  reset, asynchronous, active-high.
- cen  input  CHANNELS  per-channel clock enable.
- srst  input  1  synchronous reset/set, shared by all channels.
- din  input  CHANNELS*WIDTH  channel c occupies din[c*WIDTH +: WIDTH].
- dout  output  CHANNELS*WIDTH  last stage of each chain, same packing.
- primed  output  CHANNELS  1 when channel c has performed DEPTH loads since its last reset.

Behaviour:
- Active edge of channel c: posedge clk if NEG_MASK[c]=0, else negedge clk.
- Effective enable en_c = CE_MASK[c] ? cen[c] : 1.
- Async reset:
  - While rst=1, every stage of channel c = {WIDTH{ARST_VAL_MASK[c]}}.
  - While rst=1, load counter cnt_c = 0 and primed[c] = 0.
  - Takes effect immediately, independent of the clock.
  - Overrides srst, cen and any simultaneous edge.
  - The same values are the power-up init values.
- On the active edge with rst=0 and en_c=0: hold all stages and cnt_c. srst is ignored, because enable gates the sync reset, matching the SB_DFFESR/SB_DFFESS semantics.
- On the active edge with rst=0, en_c=1, SRST_MASK[c]=1 and srst=1:
  - Every stage = {WIDTH{SRST_VAL_MASK[c]}}.
  - cnt_c = 0, primed[c] = 0.
- On the active edge with rst=0, en_c=1 and no sync reset:
  - stage[0] <= din slice; stage[k] <= stage[k-1] for k=1..DEPTH-1.
  - cnt_c <= min(cnt_c+1, DEPTH). cnt_c saturates and never wraps.
- Outputs:
  - dout slice c = stage[DEPTH-1].
  - primed[c] = (cnt_c == DEPTH), registered on the channel's own edge.
- Latency:
  - Data reaches dout DEPTH enabled active edges after sampling.
  - DEPTH=1 gives a single register; primed rises after the first enabled load.
- srst is applied only on enabled edges of the channel's own clock edge. A negedge channel therefore samples srst at negedge.
- Counter width is clog2(DEPTH+1).
- Channels never interact, except through the shared clk, rst and srst.
- Reset deassertion is asynchronous. A reset release near an active edge is not filtered; the bench must keep rst release away from active edges.

Decomposition:
- Package ffmode_pkg:
  - function mask_bit(mask, idx).
  - Constants EDGE_POS=0 and EDGE_NEG=1.
  - function cnt_width(depth) returning clog2(depth+1).
- Sub-module ffmode_chain_chan: one channel.
  - Scalar mode parameters NEG, USE_CE, USE_SRST, SRST_VAL, ARST_VAL, plus WIDTH and DEPTH.
  - Contains the stage array, the counter and primed.
  - Written with two edge-specific always blocks selected by generate on NEG.
- Top level: generate loop over CHANNELS that slices din/dout and cen.

Test Plan:
1. Power-up/async reset, defaults with ARST_VAL_MASK=4'b0101: assert rst mid-cycle -> dout immediately 8'b00110011 and primed=0. Release rst, drive din=8'hA5 with cen=4'hF, apply 2 posedges -> dout=8'hA5 and primed=4'hF after the 2nd edge.
2. CE gating of srst, SRST_VAL_MASK=4'b0010, chain primed with 8'hFF: set srst=1 and cen=4'b0011, apply 1 edge.
   - Channels 0 and 1 dout slices become 2'b00 and 2'b11 respectively; primed[1:0]=0.
   - Channels 2 and 3 are unchanged at 2'b11 with primed=1.
3. Negedge channel, NEG_MASK=4'b1000, din[7:6]=2'b10:
   - After 2 posedges only: channel 3 dout is still at its reset value.
   - After 2 negedges: channel 3 dout=2'b10.
   - srst pulsed high for a posedge-to-negedge window resets channel 3 only at the negedge.
4. CE_MASK=4'b1110 with cen=0: after DEPTH edges, channel 0 has loaded din and primed[0]=1; channels 1-3 hold their reset values and primed=0.
5. Saturation and mid-operation reset, DEPTH=3: apply 10 enabled edges -> primed stays 1, with no wrap to 0. Assert rst between edges -> dout = ARST values immediately and primed=0. Release, apply 2 enabled edges -> primed=0; 3rd edge -> primed=1.
6. DEPTH=1, WIDTH=1, CHANNELS=1 corner: din toggled every edge -> dout follows with 1-edge latency, and primed=1 after the first enabled edge.
